// File: rtl/mux8x1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux8x1_pkg
// Brief    : Shared constants, state encoding and helpers for the 8-to-1
//            mux scan controller.
// Revision : 1.0 - initial release
// ============================================================================
package mux8x1_pkg;

    localparam int N      = 8;
    localparam int SEL_W  = 3;
    localparam int DATA_W = 4;

    // Code 2'b11 is unused; the controller steers it back to IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SAMPLE = 2'b01,
        HOLD   = 2'b10
    } state_t;

    // One-hot decode of a channel index.
    function automatic logic [N-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [N-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick8.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick8
// Brief    : Combinational round-robin picker. The search starts one past the
//            last-granted channel and wraps 7 -> 0.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick8
    import mux8x1_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] lg,
    output logic [SEL_W-1:0] pick,
    output logic             any
);

    logic [SEL_W-1:0] w_offset;
    logic [2*N-1:0]   w_dbl;
    logic [N-1:0]     w_rot;
    logic [SEL_W-1:0] w_idx;

    // Offset wraps naturally in SEL_W bits, giving (lg+1) mod N.
    assign w_offset = lg + SEL_W'(1);
    assign w_dbl    = {req, req};
    // Rotating right by the offset puts the highest-priority channel at bit 0.
    assign w_rot    = w_dbl[w_offset +: N];

    // Fixed-priority encode: lowest set bit of the rotated vector wins.
    always_comb begin
        w_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_idx = SEL_W'(i);
            end
        end
    end

    // Undo the rotation; the sum wraps mod N in SEL_W bits.
    assign pick = w_idx + w_offset;
    assign any  = |req;

endmodule
`default_nettype wire

// File: rtl/mux8x1_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mux8x1_scan_ctrl
// Brief    : Round-robin sequencer for an 8-to-1 mux. Drives the select,
//            samples the mux output one cycle later and offers it downstream
//            on a valid/ready handshake, tagged with its channel number.
// Revision : 1.0 - initial release
// ============================================================================
module mux8x1_scan_ctrl
    import mux8x1_pkg::*;
(
    input  logic              clk,
    input  logic              reset_L,
    input  logic [N-1:0]      req,
    input  logic [DATA_W-1:0] Q,
    output logic [SEL_W-1:0]  S,
    output logic [N-1:0]      gnt,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    state_t            r_state;
    logic [SEL_W-1:0]  r_lg;
    logic [SEL_W-1:0]  r_sel;
    logic [N-1:0]      r_gnt;
    logic [DATA_W-1:0] r_data;
    logic [SEL_W-1:0]  r_ch;
    logic              r_valid;

    logic [SEL_W-1:0]  w_pick;
    logic              w_any;

    rr_pick8 u_pick (
        .req  (req),
        .lg   (r_lg),
        .pick (w_pick),
        .any  (w_any)
    );

    // Sequencer: IDLE picks a channel, SAMPLE captures Q, HOLD waits for ready.
    // The grant is registered so it is high exactly during the SAMPLE cycle.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= IDLE;
            r_lg    <= SEL_W'(N - 1);
            r_sel   <= '0;
            r_gnt   <= '0;
            r_data  <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_sel   <= w_pick;
                        r_lg    <= w_pick;
                        r_gnt   <= sel_onehot(w_pick);
                        r_state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    // Decision is final: capture even if the request dropped.
                    r_data  <= Q;
                    r_ch    <= r_sel;
                    r_valid <= 1'b1;
                    r_gnt   <= '0;
                    r_state <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        if (w_any) begin
                            r_sel   <= w_pick;
                            r_lg    <= w_pick;
                            r_gnt   <= sel_onehot(w_pick);
                            r_state <= SAMPLE;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign S         = r_sel;
    assign gnt       = r_gnt;
    assign out_data  = r_data;
    assign out_ch    = r_ch;
    assign out_valid = r_valid;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mux8x1_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux8x1_scan_ctrl
// Brief    : Directed self-checking bench for mux8x1_scan_ctrl with a
//            behavioural 8-to-1 mux closing the Q feedback loop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux8x1_scan_ctrl;

    logic       clk;
    logic       reset_L;
    logic [7:0] req;
    logic [3:0] Q;
    logic [2:0] S;
    logic [7:0] gnt;
    logic [3:0] out_data;
    logic [2:0] out_ch;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    logic [3:0] mux_in [8];

    int n_checks;
    int n_errors;

    mux8x1_scan_ctrl dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .req       (req),
        .Q         (Q),
        .S         (S),
        .gnt       (gnt),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    // Behavioural stand-in for the Mux8x1 instance.
    assign Q = mux_in[S];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 reset_L = 1'b0;
        #3 reset_L = 1'b1;
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset_L   = 1'b0;
        req       = 8'h00;
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) mux_in[k] = 4'(k);

        // Reset state
        #12;
        check("rst_S", S, 0);
        check("rst_gnt", gnt, 0);
        check("rst_data", out_data, 0);
        check("rst_ch", out_ch, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        reset_L = 1'b1;
        #1;

        // Single request on channel 5
        mux_in[5] = 4'hA;
        req       = 8'h20;
        out_ready = 1'b1;
        tick();
        check("single_S", S, 5);
        check("single_gnt", gnt, 8'h20);
        check("single_busy", busy, 1);
        check("single_valid_early", out_valid, 0);
        req = 8'h00;
        tick();
        check("single_valid", out_valid, 1);
        check("single_data", out_data, 4'hA);
        check("single_ch", out_ch, 5);
        check("single_gnt_off", gnt, 0);
        tick();
        check("single_idle_valid", out_valid, 0);
        check("single_idle_busy", busy, 0);

        // Backpressure: word must stay frozen while the mux input changes
        req       = 8'h04;
        out_ready = 1'b0;
        tick();
        check("bp_S", S, 2);
        check("bp_gnt", gnt, 8'h04);
        req = 8'h00;
        tick();
        check("bp_data", out_data, 2);
        mux_in[2] = 4'hF;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold_data", out_data, 2);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_gnt", gnt, 0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_accept_valid", out_valid, 0);
        check("bp_accept_busy", busy, 0);

        // Asynchronous reset while holding a word
        req       = 8'h08;
        out_ready = 1'b0;
        tick();
        check("ar_S", S, 3);
        tick();
        check("ar_valid_pre", out_valid, 1);
        #2 reset_L = 1'b0;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_gnt", gnt, 0);
        check("ar_S0", S, 0);
        check("ar_busy", busy, 0);
        req = 8'h01;
        #1 reset_L = 1'b1;
        tick();
        check("ar_first_gnt", gnt, 8'h01);
        check("ar_first_S", S, 0);
        req       = 8'h00;
        out_ready = 1'b1;
        tick();
        tick();
        check("ar_done_busy", busy, 0);

        // Round-robin wrap with every channel requesting
        do_reset();
        for (int k = 0; k < 8; k++) mux_in[k] = 4'(k);
        req       = 8'hFF;
        out_ready = 1'b1;
        for (int w = 0; w < 10; w++) begin
            tick();
            check("rr_S", S, w % 8);
            check("rr_gnt", gnt, 32'(1) << (w % 8));
            check("rr_valid_low", out_valid, 0);
            if (w == 9) req = 8'h00;
            tick();
            check("rr_valid", out_valid, 1);
            check("rr_ch", out_ch, w % 8);
            check("rr_data", out_data, w % 8);
        end
        tick();
        check("rr_idle_busy", busy, 0);

        // Pointer fairness: park lg at 6, then req=0x41 serves 0 before 6
        req = 8'h40;
        tick();
        check("fair_setup_S", S, 6);
        req = 8'h00;
        tick();
        tick();
        check("fair_setup_idle", busy, 0);
        req = 8'h41;
        tick();
        check("fair_pick0", S, 0);
        check("fair_gnt0", gnt, 8'h01);
        tick();
        check("fair_ch0", out_ch, 0);
        tick();
        check("fair_pick6", S, 6);
        check("fair_gnt6", gnt, 8'h40);
        req = 8'h00;
        tick();
        check("fair_ch6", out_ch, 6);
        check("fair_data6", out_data, 6);
        tick();
        check("fair_idle", busy, 0);

        // Request withdrawal during SAMPLE
        req = 8'h18;
        tick();
        check("wd_S", S, 3);
        check("wd_gnt", gnt, 8'h08);
        req = 8'h10;
        tick();
        check("wd_ch", out_ch, 3);
        check("wd_data", out_data, 3);
        check("wd_valid", out_valid, 1);
        tick();
        check("wd_next_S", S, 4);
        check("wd_next_gnt", gnt, 8'h10);
        req = 8'h00;
        tick();
        check("wd_next_ch", out_ch, 4);
        tick();
        check("wd_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
